// File: rtl/step_controller_if.sv
// Control/status bundle between the step controller and the CPU/board side.
// The controller takes the slave view; the board/CPU side takes the master view.
interface step_controller_if #(
    parameter int unsigned NUM_BTN = 2,
    parameter int unsigned PC_W    = 32,
    parameter int unsigned CNT_W   = 16
);
    logic [NUM_BTN-1:0] button;
    logic               bp_en;
    logic [PC_W-1:0]    bp_addr;
    logic [PC_W-1:0]    pc;
    logic [NUM_BTN-1:0] btn_pulse;
    logic               cpu_en;
    logic               halted;
    logic               bp_hit;
    logic [CNT_W-1:0]   instr_count;

    modport master (
        output button, bp_en, bp_addr, pc,
        input  btn_pulse, cpu_en, halted, bp_hit, instr_count
    );

    modport slave (
        input  button, bp_en, bp_addr, pc,
        output btn_pulse, cpu_en, halted, bp_hit, instr_count
    );
endinterface

// File: rtl/step_controller.sv
// Execution-control front end: debounced buttons, single-step, rate-divided free run
// and run-to-breakpoint, driving the CPU state-update enable and an instruction counter.
module step_controller #(
    parameter int unsigned NUM_BTN         = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned PC_W            = 32,
    parameter int unsigned CNT_W           = 16,
    parameter int unsigned RUN_DIV         = 0
) (
    input logic              i_clk,
    input logic              i_rst_n,
    step_controller_if.slave ctrl
);
    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned DIV_W = (RUN_DIV > 0) ? $clog2(RUN_DIV + 1) : 1;

    typedef enum logic [1:0] {
        StHalt,
        StStep,
        StRun
    } state_e;

    logic [NUM_BTN-1:0] r_sync1;
    logic [NUM_BTN-1:0] r_sync2;
    logic [NUM_BTN-1:0] w_pulse;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= ctrl.button;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_db
        logic [DB_W-1:0] r_cnt;
        logic [DB_W-1:0] w_cnt_inc;
        logic            r_stable;
        logic            r_pulse;

        assign w_cnt_inc  = r_cnt + 1'b1;
        assign w_pulse[g] = r_pulse;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_cnt    <= '0;
                r_stable <= 1'b1;
                r_pulse  <= 1'b0;
            end else begin
                r_pulse <= 1'b0;
                if (r_sync2[g] == r_stable) begin
                    r_cnt <= '0;
                end else if (w_cnt_inc == DB_W'(DEBOUNCE_CYCLES)) begin
                    r_cnt    <= '0;
                    r_stable <= r_sync2[g];
                    // Only a press (level going low) is reported.
                    r_pulse  <= ~r_sync2[g];
                end else begin
                    r_cnt <= w_cnt_inc;
                end
            end
        end
    end

    state_e             r_state;
    logic [DIV_W-1:0]   r_div;
    logic               r_first_en;
    logic               r_bp_hit;
    logic [CNT_W-1:0]   r_count;
    logic               w_slot;
    logic               w_bp_match;
    logic               w_cpu_en;

    assign w_slot     = (r_div == '0);
    // first_en lets the instruction sitting on the breakpoint execute on resume.
    assign w_bp_match = ctrl.bp_en && (ctrl.pc == ctrl.bp_addr) && !r_first_en;

    always_comb begin
        w_cpu_en = 1'b0;
        unique case (r_state)
            StStep:  w_cpu_en = 1'b1;
            StRun:   w_cpu_en = !w_pulse[1] && w_slot && !w_bp_match;
            default: w_cpu_en = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StHalt;
            r_div      <= '0;
            r_first_en <= 1'b0;
            r_bp_hit   <= 1'b0;
            r_count    <= '0;
        end else begin
            if (w_cpu_en) begin
                r_count <= r_count + 1'b1;
            end
            unique case (r_state)
                StHalt: begin
                    if (w_pulse[1]) begin
                        r_state    <= StRun;
                        r_bp_hit   <= 1'b0;
                        r_div      <= '0;
                        r_first_en <= 1'b1;
                    end else if (w_pulse[0]) begin
                        r_state  <= StStep;
                        r_bp_hit <= 1'b0;
                    end
                end
                StStep: begin
                    r_state <= StHalt;
                end
                StRun: begin
                    if (w_pulse[1]) begin
                        r_state <= StHalt;
                    end else if (w_slot && w_bp_match) begin
                        r_state  <= StHalt;
                        r_bp_hit <= 1'b1;
                    end else begin
                        if (w_slot) begin
                            r_first_en <= 1'b0;
                        end
                        if (r_div == DIV_W'(RUN_DIV)) begin
                            r_div <= '0;
                        end else begin
                            r_div <= r_div + 1'b1;
                        end
                    end
                end
                default: r_state <= StHalt;
            endcase
        end
    end

    assign ctrl.btn_pulse   = w_pulse;
    assign ctrl.cpu_en      = w_cpu_en;
    assign ctrl.halted      = (r_state == StHalt);
    assign ctrl.bp_hit      = r_bp_hit;
    assign ctrl.instr_count = r_count;
endmodule

// File: tb/tb_step_controller.sv
// Scoreboarded bench for step_controller: expected enables (pc, spacing) are queued by the
// stimulus and popped by a monitor whenever cpu_en is presented.
module tb_step_controller;
    localparam int unsigned NB = 2;
    localparam int unsigned PW = 8;
    localparam int unsigned CW = 4;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic pc_clr = 1'b1;

    always #5 clk = ~clk;

    step_controller_if #(.NUM_BTN(NB), .PC_W(PW), .CNT_W(CW)) bus ();

    step_controller #(
        .NUM_BTN        (NB),
        .DEBOUNCE_CYCLES(4),
        .PC_W           (PW),
        .CNT_W          (CW),
        .RUN_DIV        (2)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .ctrl   (bus)
    );

    typedef struct {
        logic [PW-1:0] pc;
        int            gap;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks   = 0;
    int   n_pass     = 0;
    int   en_seen    = 0;
    int   pulse_cnt0 = 0;
    int   pulse_cnt1 = 0;
    int   mon_cyc    = 0;
    int   mon_last   = 0;
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic push_exp(input logic [PW-1:0] p, input int g);
        exp_t e;
        e.pc  = p;
        e.gap = g;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_pulse(input int ch, input string name);
        int b;
        b = 0;
        @(negedge clk);
        while (!bus.btn_pulse[ch] && b < 40) begin
            @(negedge clk);
            b++;
        end
        check(name, 32'(bus.btn_pulse[ch]), 32'd1);
    endtask

    task automatic wait_halt(input string name);
        int b;
        b = 0;
        @(negedge clk);
        while (!bus.halted && b < 100) begin
            @(negedge clk);
            b++;
        end
        check(name, 32'(bus.halted), 32'd1);
    endtask

    // CPU model: pc advances by 4 on every enabled edge.
    always @(posedge clk) begin
        if (pc_clr) bus.pc <= '0;
        else if (bus.cpu_en) bus.pc <= bus.pc + 8'd4;
    end

    initial begin
        forever begin
            @(negedge clk);
            mon_cyc++;
            if (bus.btn_pulse[0] === 1'b1) pulse_cnt0++;
            if (bus.btn_pulse[1] === 1'b1) pulse_cnt1++;
            if (bus.cpu_en === 1'b1) begin
                en_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_cpu_en", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("en_pc", 32'(bus.pc), 32'(mon_e.pc));
                    if (mon_e.gap != 0) check("en_gap", 32'(mon_cyc - mon_last), 32'(mon_e.gap));
                end
                mon_last = mon_cyc;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int seen;
        int b;
        int en0;
        bus.button  = '1;
        bus.bp_en   = 1'b0;
        bus.bp_addr = '0;

        // 1. reset state
        tick(5);
        check("rst_halted", 32'(bus.halted), 32'd1);
        check("rst_cpu_en", 32'(bus.cpu_en), 32'd0);
        check("rst_pulse", 32'(bus.btn_pulse), 32'd0);
        check("rst_bp_hit", 32'(bus.bp_hit), 32'd0);
        check("rst_count", 32'(bus.instr_count), 32'd0);
        rst_n = 1'b1;
        tick(1);
        pc_clr = 1'b0;
        tick(2);

        // 2. bouncy single step
        push_exp(8'h00, 0);
        bus.button[0] = 1'b0;
        tick(3);
        bus.button[0] = 1'b1;
        tick(1);
        bus.button[0] = 1'b0;
        wait_pulse(0, "step_pulse");
        check("step_pre_en", 32'(bus.cpu_en), 32'd0);
        tick(1);
        check("step_en", 32'(bus.cpu_en), 32'd1);
        check("step_not_halted", 32'(bus.halted), 32'd0);
        tick(1);
        check("step_back_halt", 32'(bus.halted), 32'd1);
        tick(4);
        bus.button[0] = 1'b1;
        tick(10);
        check("step_pulse_count", 32'(pulse_cnt0), 32'd1);
        check("step_no_run_pulse", 32'(pulse_cnt1), 32'd0);
        check("step_count", 32'(bus.instr_count), 32'd1);

        // 3. free run, 1-in-3 enables, halted by second run press after 4 enables
        push_exp(8'h04, 0);
        push_exp(8'h08, 3);
        push_exp(8'h0c, 3);
        push_exp(8'h10, 3);
        bus.button[1] = 1'b0;
        wait_pulse(1, "run_pulse");
        bus.button[1] = 1'b1;
        seen = 0;
        b    = 0;
        while (seen < 2 && b < 40) begin
            @(negedge clk);
            b++;
            if (bus.cpu_en) seen++;
        end
        check("run_two_enables", 32'(seen), 32'd2);
        tick(1);
        bus.button[1] = 1'b0;
        wait_halt("run_halt");
        bus.button[1] = 1'b1;
        tick(10);
        check("run_count", 32'(bus.instr_count), 32'd5);
        check("run_queue_empty", 32'(exp_q.size()), 32'd0);

        // 4. run to breakpoint, then resume through it
        pc_clr = 1'b1;
        tick(1);
        pc_clr      = 1'b0;
        bus.bp_en   = 1'b1;
        bus.bp_addr = 8'h10;
        push_exp(8'h00, 0);
        push_exp(8'h04, 3);
        push_exp(8'h08, 3);
        push_exp(8'h0c, 3);
        bus.button[1] = 1'b0;
        wait_pulse(1, "bp_run_pulse");
        bus.button[1] = 1'b1;
        wait_halt("bp_halt");
        tick(8);
        check("bp_hit_set", 32'(bus.bp_hit), 32'd1);
        check("bp_count", 32'(bus.instr_count), 32'd9);
        check("bp_pc", 32'(bus.pc), 32'h10);
        push_exp(8'h10, 0);
        push_exp(8'h14, 3);
        bus.button[1] = 1'b0;
        wait_pulse(1, "bp_resume_pulse");
        bus.button[1] = 1'b1;
        tick(1);
        check("bp_hit_cleared", 32'(bus.bp_hit), 32'd0);
        check("bp_resume_en", 32'(bus.cpu_en), 32'd1);
        bus.bp_addr = 8'h18;
        wait_halt("bp2_halt");
        tick(8);
        check("bp2_hit", 32'(bus.bp_hit), 32'd1);
        check("bp2_count", 32'(bus.instr_count), 32'd11);
        check("bp2_pc", 32'(bus.pc), 32'h18);

        // 5. both buttons together: run wins
        pc_clr = 1'b1;
        tick(1);
        pc_clr      = 1'b0;
        bus.bp_addr = 8'h0c;
        push_exp(8'h00, 0);
        push_exp(8'h04, 3);
        push_exp(8'h08, 3);
        bus.button = 2'b00;
        wait_pulse(1, "both_pulse");
        check("both_step_pulse", 32'(bus.btn_pulse[0]), 32'd1);
        bus.button = 2'b11;
        tick(1);
        check("both_running1", 32'(bus.halted), 32'd0);
        tick(1);
        check("both_running2", 32'(bus.halted), 32'd0);
        wait_halt("both_halt");
        tick(8);
        check("both_count", 32'(bus.instr_count), 32'd14);
        check("both_bp_hit", 32'(bus.bp_hit), 32'd1);

        // 6. async reset in the middle of a run
        bus.bp_en = 1'b0;
        push_exp(8'h0c, 0);
        push_exp(8'h10, 3);
        bus.button[1] = 1'b0;
        wait_pulse(1, "rr_pulse");
        bus.button[1] = 1'b1;
        tick(1);
        check("rr_first_en", 32'(bus.cpu_en), 32'd1);
        tick(3);
        check("rr_second_en", 32'(bus.cpu_en), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rr_cpu_en_low", 32'(bus.cpu_en), 32'd0);
        check("rr_halted", 32'(bus.halted), 32'd1);
        check("rr_count", 32'(bus.instr_count), 32'd0);
        check("rr_bp_hit", 32'(bus.bp_hit), 32'd0);
        tick(3);
        #2;
        rst_n = 1'b1;
        tick(1);
        pc_clr = 1'b1;
        tick(1);
        pc_clr = 1'b0;
        en0    = en_seen;
        tick(20);
        check("rr_no_enable", 32'(en_seen - en0), 32'd0);

        // 16 steps wrap the 4-bit counter
        for (int i = 0; i < 16; i++) begin
            push_exp(PW'(i * 4), 0);
            bus.button[0] = 1'b0;
            tick(8);
            bus.button[0] = 1'b1;
            tick(8);
            if (i == 14) check("wrap_count15", 32'(bus.instr_count), 32'd15);
        end
        check("wrap_count0", 32'(bus.instr_count), 32'd0);
        check("wrap_halted", 32'(bus.halted), 32'd1);
        check("exp_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/step_controller.md
Name: step_controller

Overview:
- Parametrised execution-control front end for the button-stepped single-cycle processor top level.
- Replaces the single-button debouncer with NUM_BTN debounced channels.
- Adds three execution modes: single-step, free-run with a programmable rate divider, and run-to-breakpoint.
- Drives the CPU state-update enable (cpu_en) and an executed-instruction counter for the hex displays.

Parameters:
NUM_BTN, 2, number of raw active-low buttons; btn[0]=step, btn[1]=run/halt toggle; channels >=2 are debounced only (pulse out, no control effect)
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a level change (20 ms at 50 MHz); >=1
PC_W, 32, program counter width
CNT_W, 16, instruction counter width
RUN_DIV, 0, idle cycles inserted between enables in RUN (0 = enable every cycle)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
button  in  NUM_BTN  raw active-low pushbuttons, asynchronous to clk
bp_en  in  1  breakpoint enable
bp_addr  in  PC_W  breakpoint address
pc  in  PC_W  current CPU PC; updates on the clk edge where cpu_en=1
btn_pulse  out  NUM_BTN  one-cycle pulse per accepted press
cpu_en  out  1  CPU state-update enable
halted  out  1  high in HALT state
bp_hit  out  1  sticky breakpoint-stop flag
instr_count  out  CNT_W  number of cpu_en cycles, wrapping

Behaviour:
- Reset (reset=0, async):
  - sync flops=1, stable levels=1 (released), debounce counters=0.
  - btn_pulse=0, state=HALT, run divider=0, bp_hit=0, instr_count=0.
  - cpu_en=0 and halted=1 immediately, before the next clk edge.
- Debounce, per channel:
  - 2-flop synchroniser, then a compare against the stable level.
  - Counter increments while sync != stable and clears to 0 whenever sync == stable.
  - On reaching DEBOUNCE_CYCLES the stable level takes the sync value and the counter clears.
  - Stable 1->0 sets btn_pulse[i] (registered) high for exactly the next cycle.
  - Stable 0->1 (release) produces no pulse. A held button produces one pulse only.
- FSM states: HALT, STEP, RUN. All transitions happen on the edge where btn_pulse is sampled high.
  - HALT:
    - btn_pulse[1] -> RUN: clear bp_hit, divider=0, set first_en flag.
    - else btn_pulse[0] -> STEP: clear bp_hit.
    - Both pulses together: RUN wins.
  - STEP: cpu_en=1 for exactly this one cycle, then unconditionally -> HALT. Breakpoint not checked. Pulses arriving in STEP are dropped.
  - RUN:
    - Divider counts 0..RUN_DIV, wrapping. An enable slot exists when divider==0.
    - In a slot: if bp_en && pc==bp_addr && !first_en, then cpu_en=0, bp_hit<=1, -> HALT.
    - Otherwise cpu_en=1 and first_en clears. first_en guarantees the instruction at a breakpoint executes when resuming.
    - btn_pulse[1] -> HALT; cpu_en is forced 0 in that cycle. btn_pulse[0] is ignored.
- cpu_en is decoded combinationally from the registered state, the divider, first_en and the pc compare. It is not registered, so the CPU samples it at the same edge.
- Press latency: btn_pulse high in cycle n; STEP (or first RUN slot) and cpu_en=1 in cycle n+1.
- instr_count increments on every edge with cpu_en=1; 2^CNT_W-1 wraps to 0.
- halted = (state==HALT).
- bp_hit holds until the next STEP or RUN entry or reset.
- bp_en or bp_addr changing mid-RUN takes effect at the next slot.

Test Plan:
Params for all scenarios: DEBOUNCE_CYCLES=4, RUN_DIV=2, CNT_W=4, PC_W=8. The bench drives pc +4 on each cpu_en edge, starting from 0.

1. Hold reset low 5 cycles, all buttons high -> halted=1, cpu_en=0, btn_pulse=0, bp_hit=0, instr_count=0.
2. button[0] low 3 cycles, high 1, low 12, then high -> exactly one btn_pulse[0]; exactly one cpu_en cycle the cycle after it; instr_count=1; halted=1; no pulse on release.
3. Press button[1] -> cpu_en pattern 1,0,0,1,0,0,... Press button[1] again after 4 enables -> halted=1, no further cpu_en, instr_count=5 (1 from the earlier step).
4. bp_en=1, bp_addr=0x10, pc=0, press run -> enables at pc 0x00,0x04,0x08,0x0C; at pc=0x10 cpu_en stays 0, bp_hit=1, halted=1, count +4. Press run again -> bp_hit=0, enable executes at pc=0x10, then pc=0x14.
5. button[0] and button[1] pressed in the same cycle while HALT -> RUN entered, no STEP cycle. Sixteen single steps from count 0 -> instr_count returns to 0.
6. Assert reset mid-RUN between edges -> cpu_en=0 and halted=1 before the next edge; instr_count=0. After release, no enable until a new press.
